vector_capture: RTL and testbench
=================================

Name: vector_capture

Overview:
Synthesizable capture engine that is the hardware-side counterpart of the testbench output-vector writer. It samples a DUT output vector every clock once a mask/value trigger fires, and buffers the samples in an on-chip FIFO. It drains them to a host over a valid/ready stream, so captured vectors can be dumped in the same one-hex-word-per-cycle order the bench produces. It sits between the DUT output bus and the host readback path.

Parameters:
VECTOR_W, 32, width of sampled vector and of drain data
FIFO_DEPTH, 512, capture buffer depth in entries; power of two, at least 4
LEN_W, 16, width of the capture length register

Ports:
clk  in  1  system clock; all logic is on the rising edge
logic_reset  in  1  reset; asynchronous and active-high; clears all state
sample_vector  in  VECTOR_W  DUT output vector, sampled every clk
trig_mask  in  VECTOR_W  trigger mask; a 1 bit means that bit is compared
trig_value  in  VECTOR_W  trigger compare value
capture_len  in  LEN_W  number of samples to capture; 0 means unlimited until stop
arm  in  1  single-cycle pulse: arm the capture
stop  in  1  single-cycle pulse: end the capture
m_data  out  VECTOR_W  drain data
m_valid  out  1  drain data valid
m_ready  in  1  host accepts m_data
state_o  out  2  current state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
overflow  out  1  sticky flag: at least one sample was dropped
level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync use after deassert): state IDLE; FIFO empty; m_valid=0; m_data=0; overflow=0; level=0; internal sample count=0.
- Trigger hit: (sample_vector & trig_mask) == (trig_value & trig_mask). A mask of 0 triggers immediately.
- State machine:
  - IDLE: arm -> ARMED. Arm also clears overflow and the sample count. The FIFO is not flushed.
  - ARMED: trigger hit -> CAPTURE, and the triggering cycle's vector is written as sample 0. stop -> DONE.
  - CAPTURE: write sample_vector every cycle. The count increments per attempted write, including dropped ones.
    - capture_len != 0 and count reaches capture_len -> DONE. Exactly capture_len samples are attempted.
    - stop -> DONE; no write occurs on the stop cycle.
  - DONE: arm -> ARMED, clearing overflow and the count.
  - arm in ARMED or CAPTURE is ignored.
  - stop in IDLE or DONE is ignored.
  - arm and stop in the same cycle: stop wins.
- Latching: capture_len, trig_mask and trig_value are latched on the arm cycle. Later changes have no effect until the next arm.
- FIFO: first-word-fall-through.
  - A sample written at edge N is visible on m_data with m_valid=1 after edge N, i.e. during cycle N+1 when the FIFO was empty.
  - Pop occurs when m_valid && m_ready.
  - m_data holds stable while m_valid && !m_ready.
- Full: a write while full is dropped and sets overflow, unless a pop happens in the same cycle, in which case the write is accepted.
- Empty: m_valid=0; m_data holds its last value.
- Simultaneous push and pop: level is unchanged.
- Pointers are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. level is derived from a separate count register.
- Draining is allowed in every state, including during CAPTURE.
- Reset mid-capture: everything returns to reset values immediately; FIFO contents are discarded.

Decomposition:
- Shared package (capture_pkg):
  - state enum, 2 bits
  - localparam PTR_W = clog2(FIFO_DEPTH)
  - localparam LVL_W = PTR_W + 1
- Sub-module capture_fifo: synchronous FWFT FIFO with push/pop/full/empty/level ports.
- The FSM, trigger compare and counters live in vector_capture.

Test Plan:
- Basic capture: arm, mask=0, capture_len=4, vector=counter 0x10..; m_ready=1 -> m_data sequence 0x10,0x11,0x12,0x13; state ends DONE; overflow=0.
- Trigger match: mask=0x0000FFFF, value=0x0000BEEF; drive 0x1234BEEF at cycle 7; capture_len=2 -> first word 0x1234BEEF, then the cycle-8 vector; no earlier words.
- Overflow: FIFO_DEPTH=8, m_ready=0, capture_len=10 -> level=8; overflow=1; draining yields the first 8 samples in order.
- Backpressure: toggle m_ready 1-0-1 -> m_data stable while not ready; no loss or duplication; the full-with-pop cycle accepts the write.
- Stop and arm: unlimited length; stop after 5 samples -> exactly 5 words, DONE. arm+stop in the same cycle while ARMED -> DONE. Rearm -> overflow cleared.
- Async reset during CAPTURE at mid-cycle -> outputs are reset values before the next clk edge; level=0; state IDLE.

Source files
------------

// File: rtl/capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : capture_pkg                                            |
// | Description : Shared types and default sizing for the vector capture |
// |               engine (state encoding, pointer/level widths).         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package capture_pkg;

  // Capture engine states; encoding is visible to software on state_o.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Default buffer depth and the pointer/level widths it implies.
  localparam int DEFAULT_FIFO_DEPTH = 512;
  localparam int PTR_W = $clog2(DEFAULT_FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

endpackage : capture_pkg
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : capture_fifo                                           |
// | Description : First-word-fall-through FIFO. Head entry is visible    |
// |               on data_o whenever not empty; when empty, data_o holds |
// |               the last word popped. A push while full is accepted    |
// |               only if a pop happens in the same cycle.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module capture_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] last_q;

  logic w_do_pop;
  logic w_do_push;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign level_o   = count_q;
  assign w_do_pop  = pop_i & ~empty_o;
  // The slot freed by a same-cycle pop makes room for a push into a full FIFO.
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign data_o    = empty_o ? last_q : mem_q[rd_ptr_q];

  // Storage array; contents need no reset since count_q gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers, occupancy and the hold register shown while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      if (w_do_push && !w_do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule : capture_fifo
`default_nettype wire

// File: rtl/vector_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vector_capture                                         |
// | Description : Trigger-qualified capture of a DUT output vector into  |
// |               a FWFT buffer, drained to the host over valid/ready.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module vector_capture
  import capture_pkg::*;
#(
  parameter int VECTOR_W   = 32,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int LEN_W      = 16
) (
  input  logic                        clk,
  input  logic                        logic_reset,
  input  logic [VECTOR_W-1:0]         sample_vector,
  input  logic [VECTOR_W-1:0]         trig_mask,
  input  logic [VECTOR_W-1:0]         trig_value,
  input  logic [LEN_W-1:0]            capture_len,
  input  logic                        arm,
  input  logic                        stop,
  output logic [VECTOR_W-1:0]         m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [1:0]                  state_o,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [LEN_W-1:0]    len_q;
  logic [VECTOR_W-1:0] mask_q;
  logic [VECTOR_W-1:0] value_q;
  logic                overflow_q;

  logic                w_hit;
  logic                w_write;
  logic                w_arm_take;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [LEN_W-1:0]    w_cnt_inc;
  logic                w_len_hit;

  assign w_hit     = ((sample_vector ^ value_q) & mask_q) == '0;
  assign w_cnt_inc = count_q + 1'b1;
  // This write is the last one when a finite length is reached.
  assign w_len_hit = (len_q != '0) && (w_cnt_inc == len_q);
  assign m_valid   = ~w_empty;
  assign w_pop     = m_valid & m_ready;
  assign state_o   = state_q;
  assign overflow  = overflow_q;

  // Next-state, sample-write and arm-acceptance decode; stop beats arm.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    w_write    = 1'b0;
    w_arm_take = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm && !stop) begin
          state_d    = ST_ARMED;
          count_d    = '0;
          w_arm_take = 1'b1;
        end
      end
      ST_ARMED: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (w_hit) begin
          w_write = 1'b1;
          count_d = w_cnt_inc;
          state_d = w_len_hit ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (stop) begin
          state_d = ST_DONE;
        end else begin
          w_write = 1'b1;
          count_d = w_cnt_inc;
          if (w_len_hit) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, sample count, arm-time latches and the sticky drop flag.
  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      len_q      <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (w_arm_take) begin
        len_q      <= capture_len;
        mask_q     <= trig_mask;
        value_q    <= trig_value;
        overflow_q <= 1'b0;
      end else if (w_write && w_full && !w_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  capture_fifo #(
    .DATA_W (VECTOR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (logic_reset),
    .push_i      (w_write),
    .push_data_i (sample_vector),
    .pop_i       (w_pop),
    .data_o      (m_data),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (level)
  );

endmodule : vector_capture
`default_nettype wire

// File: tb/tb_vector_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_vector_capture                                      |
// | Description : Self-checking bench for vector_capture with a queue    |
// |               based reference model and directed/random stimulus.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_vector_capture;

  localparam int VW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 16;
  localparam int LVW   = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           logic_reset;
  logic [VW-1:0]  sample_vector;
  logic [VW-1:0]  trig_mask;
  logic [VW-1:0]  trig_value;
  logic [LW-1:0]  capture_len;
  logic           arm;
  logic           stop;
  logic [VW-1:0]  m_data;
  logic           m_valid;
  logic           m_ready;
  logic [1:0]     state_o;
  logic           overflow;
  logic [LVW-1:0] level;

  always #5 clk = ~clk;

  vector_capture #(
    .VECTOR_W   (VW),
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LW)
  ) dut (
    .clk           (clk),
    .logic_reset   (logic_reset),
    .sample_vector (sample_vector),
    .trig_mask     (trig_mask),
    .trig_value    (trig_value),
    .capture_len   (capture_len),
    .arm           (arm),
    .stop          (stop),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .state_o       (state_o),
    .overflow      (overflow),
    .level         (level)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue, capture progress is "samples left".
  int            m_state = 0;
  logic [VW-1:0] mq[$];
  logic [VW-1:0] m_last = '0;
  bit            m_ovf = 0;
  int            m_rem = 0;
  bit            m_unl = 0;
  logic [LW-1:0] m_len = '0;
  logic [VW-1:0] m_mask = '0;
  logic [VW-1:0] m_val = '0;
  logic [VW-1:0] got[$];

  function automatic void model_reset();
    m_state = 0;
    mq.delete();
    m_last = '0;
    m_ovf  = 0;
    m_rem  = 0;
    m_unl  = 0;
  endfunction

  function automatic void model_step();
    bit pop;
    bit wr;
    pop = (mq.size() > 0) && m_ready;
    wr  = 0;
    case (m_state)
      0, 3: if (arm && !stop) begin
        m_state = 1;
        m_ovf   = 0;
        m_len   = capture_len;
        m_mask  = trig_mask;
        m_val   = trig_value;
      end
      1: if (stop) m_state = 3;
         else if ((sample_vector & m_mask) == (m_val & m_mask)) begin
           wr = 1;
           m_unl = (m_len == 0);
           m_rem = int'(m_len);
           m_state = 2;
         end
      2: if (stop) m_state = 3; else wr = 1;
      default: m_state = 0;
    endcase
    if (pop) m_last = mq.pop_front();
    if (wr) begin
      if (mq.size() < DEPTH) mq.push_back(sample_vector);
      else m_ovf = 1;
      if (!m_unl) begin
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
    end
  endfunction

  function automatic logic [VW-1:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  // Record host handshakes, advance the model each edge, then compare.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!logic_reset && m_valid && m_ready) got.push_back(m_data);
      @(posedge clk);
      if (logic_reset) model_reset();
      else model_step();
      #1;
      check("m_valid",  {63'd0, m_valid},  {63'd0, mq.size() > 0});
      check("m_data",   {32'd0, m_data},   {32'd0, (mq.size() > 0) ? mq[0] : m_last});
      check("level",    {60'd0, level},    64'(mq.size()));
      check("state",    {62'd0, state_o},  64'(m_state));
      check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [VW-1:0] v;
    logic_reset = 1'b1; sample_vector = '0; trig_mask = '0; trig_value = '0;
    capture_len = '0; arm = 1'b0; stop = 1'b0; m_ready = 1'b1;
    repeat (2) step();
    logic_reset = 1'b0;
    check("rst_state", {62'd0, state_o}, 64'd0);
    check("rst_level", {60'd0, level}, 64'd0);
    check("rst_valid", {63'd0, m_valid}, 64'd0);
    check("rst_data",  {32'd0, m_data}, 64'd0);

    // Basic capture: mask 0, four samples of a counting vector.
    got.delete();
    arm = 1; trig_mask = '0; capture_len = 4; sample_vector = 32'h0F;
    step();
    arm = 0; sample_vector = 32'h10;
    for (int i = 0; i < 3; i++) begin step(); sample_vector++; end
    repeat (5) step();
    check("basic_cnt", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("basic_word", {32'd0, got_at(i)}, 64'(32'h10 + i));
    check("basic_done", {62'd0, state_o}, 64'd3);
    check("basic_ovf", {63'd0, overflow}, 64'd0);

    // Trigger match on low half; inputs changed after arm must not matter.
    got.delete();
    arm = 1; trig_mask = 32'h0000FFFF; trig_value = 32'h0000BEEF; capture_len = 2;
    sample_vector = '0;
    step();
    arm = 0; trig_mask = '0; trig_value = '0; capture_len = 9;
    for (int c = 1; c <= 12; c++) begin
      v = $urandom;
      if (v[15:0] == 16'hBEEF) v[0] = ~v[0];
      if (c == 7) v = 32'h1234BEEF;
      if (c == 8) v = 32'hCAFE0001;
      sample_vector = v;
      step();
    end
    check("trig_cnt", 64'(got.size()), 64'd2);
    check("trig_w0", {32'd0, got_at(0)}, 64'h1234BEEF);
    check("trig_w1", {32'd0, got_at(1)}, 64'hCAFE0001);

    // Overflow: no draining, ten samples into an eight-deep buffer.
    m_ready = 0; arm = 1; trig_mask = '0; capture_len = 10; sample_vector = 32'h100;
    step();
    arm = 0;
    for (int i = 0; i < 14; i++) begin sample_vector++; step(); end
    check("ovf_level", {60'd0, level}, 64'd8);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    check("ovf_state", {62'd0, state_o}, 64'd3);
    got.delete();
    m_ready = 1;
    repeat (12) step();
    check("ovf_drain_cnt", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) check("ovf_drain", {32'd0, got_at(i)}, 64'(32'h101 + i));

    // Rearm clears overflow; arm+stop while armed ends in DONE.
    arm = 1; trig_mask = '1; trig_value = 32'hDEADBEEF; capture_len = 0; sample_vector = '0;
    step();
    arm = 0;
    check("rearm_ovf", {63'd0, overflow}, 64'd0);
    check("rearm_state", {62'd0, state_o}, 64'd1);
    arm = 1; stop = 1;
    step();
    arm = 0; stop = 0;
    check("armstop_state", {62'd0, state_o}, 64'd3);

    // Backpressure: fill, then keep capturing with a toggling ready.
    m_ready = 0; arm = 1; trig_mask = '0; capture_len = 0; sample_vector = 32'h300;
    step();
    arm = 0;
    for (int i = 0; i < 50 && level != LVW'(DEPTH); i++) begin sample_vector++; step(); end
    check("bp_full", {60'd0, level}, 64'(DEPTH));
    for (int i = 0; i < 30; i++) begin
      sample_vector++;
      m_ready = (i % 3) != 1;
      step();
    end
    stop = 1; step(); stop = 0; m_ready = 1;
    repeat (12) step();

    // Stop after five samples in unlimited mode.
    got.delete();
    arm = 1; trig_mask = '0; capture_len = 0; sample_vector = 32'h200;
    step();
    arm = 0;
    for (int i = 1; i <= 5; i++) begin sample_vector = 32'h200 + i; step(); end
    stop = 1; sample_vector = 32'h206;
    step();
    stop = 0;
    repeat (4) step();
    check("stop_cnt", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5; i++) check("stop_word", {32'd0, got_at(i)}, 64'(32'h201 + i));
    check("stop_state", {62'd0, state_o}, 64'd3);

    // Asynchronous reset in the middle of a capture.
    m_ready = 0; arm = 1; trig_mask = '0; capture_len = 0;
    step();
    arm = 0;
    repeat (4) begin sample_vector++; step(); end
    check("pre_rst_level", {60'd0, level}, 64'd4);
    #3;
    logic_reset = 1;
    #1;
    check("arst_state", {62'd0, state_o}, 64'd0);
    check("arst_level", {60'd0, level}, 64'd0);
    check("arst_valid", {63'd0, m_valid}, 64'd0);
    check("arst_data",  {32'd0, m_data}, 64'd0);
    check("arst_ovf",   {63'd0, overflow}, 64'd0);
    step();
    logic_reset = 0;
    m_ready = 1;
    step();

    // Randomized sessions checked cycle by cycle against the model.
    for (int it = 0; it < 12; it++) begin
      capture_len = LW'($urandom_range(0, 12));
      trig_mask   = (it % 3 == 0) ? '0 : ($urandom & 32'h3);
      trig_value  = $urandom;
      sample_vector = $urandom;
      arm = 1;
      step();
      arm = 0;
      for (int c = 0; c < 40; c++) begin
        sample_vector = $urandom;
        m_ready = (it % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        stop = ($urandom_range(0, 19) == 0);
        arm  = ($urandom_range(0, 14) == 0);
        capture_len = LW'($urandom_range(0, 12));
        trig_mask   = $urandom;
        trig_value  = $urandom;
        step();
      end
      arm = 0; stop = 1;
      step();
      stop = 0; m_ready = 1;
      repeat (10) step();
    end

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vector_capture
`default_nettype wire
